core_ctrl_gen: RTL

Second-generation memory-mapped core control block. It keeps pause control and PC/SP readback, and adds:
- parametrised data, PC and step-counter widths;
- dual stack bound detection: overflow below a low setpoint, underflow above a high setpoint;
- sticky write-1-to-clear status flags;
- a single-step/N-step debug state machine driven by instruction-retire reports from the core.

It sits on the memory-map bus beside the core and drives the core's pause and interrupt inputs.

---
 rtl/core_ctrl_gen.sv | 163 ++++++++++++++++
 1 files changed

// File: rtl/core_ctrl_gen.sv
// Memory-mapped core control: pause/step FSM, stack bound
// detection with sticky W1C flags, and PC/SP readback.
module core_ctrl_gen #(
    parameter int DATA_W = 16,
    parameter int PC_W   = 15,
    parameter int STEP_W = 8
) (
    input  logic              i_clk,
    input  logic              i_rst,
    input  logic [2:0]        i_memAddr,
    input  logic [DATA_W-1:0] i_memDataIn,
    input  logic              i_memWrEn,
    output logic [DATA_W-1:0] o_memDataOut,
    input  logic [DATA_W-1:0] i_reportSP,
    input  logic [PC_W-1:0]   i_reportPC,
    input  logic              i_reportHLT,
    input  logic              i_reportRetire,
    output logic              o_doPause,
    output logic              o_intOVF,
    output logic              o_intUNF,
    output logic              o_stepping
);

    typedef enum logic [1:0] {
        ST_RUN,
        ST_PAUSED,
        ST_STEP
    } state_t;

    state_t            state_q, state_d;
    logic              ovf_en_q, ovf_en_d;
    logic              unf_en_q, unf_en_d;
    logic              halted_q, halted_d;
    logic              ovf_q, ovf_d;
    logic              unf_q, unf_d;
    logic [DATA_W-1:0] low_q, low_d;
    logic [DATA_W-1:0] high_q, high_d;
    logic [STEP_W-1:0] steps_q, steps_d;

    logic wr_ctrl, wr_stat, wr_low, wr_high, wr_steps;

    // Register write decode
    always_comb begin
        wr_ctrl  = i_memWrEn && (i_memAddr == 3'd0);
        wr_stat  = i_memWrEn && (i_memAddr == 3'd1);
        wr_low   = i_memWrEn && (i_memAddr == 3'd2);
        wr_high  = i_memWrEn && (i_memAddr == 3'd3);
        wr_steps = i_memWrEn && (i_memAddr == 3'd4);
    end

    // Next-state: FSM, step counter, setpoints, enables and flags
    always_comb begin
        state_d  = state_q;
        steps_d  = steps_q;
        ovf_en_d = ovf_en_q;
        unf_en_d = unf_en_q;
        low_d    = low_q;
        high_d   = high_q;

        // Retire accounting; last step lands in PAUSED on this edge
        if (state_q == ST_STEP && i_reportRetire) begin
            steps_d = steps_q - STEP_W'(1);
            if (steps_q == STEP_W'(1)) begin
                state_d = ST_PAUSED;
            end
        end

        // Count is frozen while a step run is in progress
        if (wr_steps && state_q != ST_STEP) begin
            steps_d = i_memDataIn[STEP_W-1:0];
        end

        if (wr_low) begin
            low_d = i_memDataIn;
        end
        if (wr_high) begin
            high_d = i_memDataIn;
        end

        if (wr_ctrl) begin
            ovf_en_d = i_memDataIn[1];
            unf_en_d = i_memDataIn[2];
            if (i_memDataIn[0]) begin
                state_d = ST_PAUSED;
            end else if (!i_memDataIn[3]) begin
                state_d = ST_RUN;
            end else if (state_q == ST_PAUSED && steps_q != '0) begin
                state_d = ST_STEP;
            end
        end

        // HLT beats any same-cycle CTRL write
        if (i_reportHLT) begin
            state_d = ST_PAUSED;
        end

        // Sticky flags: set beats a same-cycle clear
        halted_d = (halted_q & ~(wr_stat & i_memDataIn[0]))
                 | i_reportHLT;
        ovf_d    = (ovf_q & ~(wr_stat & i_memDataIn[1]))
                 | (ovf_en_q & (i_reportSP < low_q));
        unf_d    = (unf_q & ~(wr_stat & i_memDataIn[2]))
                 | (unf_en_q & (i_reportSP > high_q));
    end

    // State register with synchronous reset
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state_q  <= ST_RUN;
            ovf_en_q <= 1'b0;
            unf_en_q <= 1'b0;
            halted_q <= 1'b0;
            ovf_q    <= 1'b0;
            unf_q    <= 1'b0;
            low_q    <= '0;
            high_q   <= '1;
            steps_q  <= '0;
        end else begin
            state_q  <= state_d;
            ovf_en_q <= ovf_en_d;
            unf_en_q <= unf_en_d;
            halted_q <= halted_d;
            ovf_q    <= ovf_d;
            unf_q    <= unf_d;
            low_q    <= low_d;
            high_q   <= high_d;
            steps_q  <= steps_d;
        end
    end

    // Combinational read mux
    always_comb begin
        o_memDataOut = '0;
        unique case (i_memAddr)
            3'd0: begin
                o_memDataOut[0] = (state_q == ST_PAUSED);
                o_memDataOut[1] = ovf_en_q;
                o_memDataOut[2] = unf_en_q;
            end
            3'd1: begin
                o_memDataOut[0] = halted_q;
                o_memDataOut[1] = ovf_q;
                o_memDataOut[2] = unf_q;
                o_memDataOut[3] = (state_q == ST_STEP);
            end
            3'd2: o_memDataOut = low_q;
            3'd3: o_memDataOut = high_q;
            3'd4: o_memDataOut[STEP_W-1:0] = steps_q;
            3'd5: o_memDataOut = {i_reportPC, 1'b0};
            3'd6: o_memDataOut = i_reportSP;
            default: o_memDataOut = '0;
        endcase
    end

    // Core-facing outputs
    always_comb begin
        o_doPause  = (state_q == ST_PAUSED);
        o_stepping = (state_q == ST_STEP);
        o_intOVF   = ovf_q & ovf_en_q;
        o_intUNF   = unf_q & unf_en_q;
    end

endmodule
